// File: rtl/spi_dac_driver.sv
// SPI write engine for DAC856x/DAC816x quad DACs: snapshots channel codes on a trigger,
// sends one 24-bit frame per changed channel, queues one retrigger, programmable SClk rate.
module spi_dac_driver #(
   parameter int unsigned CHANNELS       = 4,
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned CLK_DIV        = 1,
   parameter int unsigned SIGNED_IN      = 1,
   parameter int unsigned UPDATE_CHANGED = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           trigger,
   input  logic                           force_all,
   input  logic [CHANNELS*DATA_WIDTH-1:0] value,
   output logic                           busy,
   output logic                           done,
   output logic                           n_sync,
   output logic                           sclk,
   output logic                           data
);
   localparam int unsigned VW  = CHANNELS * DATA_WIDTH;
   localparam int unsigned PAD = 16 - DATA_WIDTH;
   localparam int unsigned FW  = 24;
   localparam int unsigned CW  = 2;
   localparam int unsigned BW  = 5;
   localparam int unsigned DW  = 8;

   typedef enum logic [2:0] {
      S_IDLE, S_EVAL, S_LOAD, S_SETUP, S_LOW, S_HIGH, S_END
   } state_t;

   state_t                state, state_next;
   logic                  trig_prev, edge_c;
   logic                  force_q, pend, pend_force, valid, fin_q;
   logic                  finish_c, restart_c, phase_end, frame_act;
   logic [VW-1:0]         shadow, cur;
   logic [CHANNELS-1:0]   mask, eval_mask, mask_rem, chg;
   logic [CW-1:0]         lo, hi;
   logic [DATA_WIDTH-1:0] code;
   logic [15:0]           d16;
   logic [FW-1:0]         frame, frame_c;
   logic [BW-1:0]         bit_cnt;
   logic [DW-1:0]         div_cnt;

   assign edge_c    = trigger & ~trig_prev;
   assign phase_end = (div_cnt == DW'(CLK_DIV - 1));
   assign frame_act = (state == S_SETUP) || (state == S_LOW) || (state == S_HIGH);

   // Channels to send for this transaction
   always_comb begin
      chg = '0;
      for (int k = 0; k < CHANNELS; k++)
         chg[k] = (value[k*DATA_WIDTH +: DATA_WIDTH] != shadow[k*DATA_WIDTH +: DATA_WIDTH]);
      if (UPDATE_CHANGED != 0) eval_mask = chg | {CHANNELS{force_q | ~valid}};
      else                     eval_mask = '1;
   end

   // Next frame: lowest pending channel; the highest pending one carries the load bit
   always_comb begin
      lo = '0;
      hi = '0;
      for (int k = CHANNELS - 1; k >= 0; k--)
         if (mask[k]) lo = CW'(k);
      for (int k = 0; k < CHANNELS; k++)
         if (mask[k]) hi = CW'(k);
      code     = '0;
      mask_rem = mask;
      for (int k = 0; k < CHANNELS; k++) begin
         if (CW'(k) == lo) begin
            code        = cur[k*DATA_WIDTH +: DATA_WIDTH];
            mask_rem[k] = 1'b0;
         end
      end
      if (SIGNED_IN != 0) code[DATA_WIDTH-1] = ~code[DATA_WIDTH-1];
      d16     = 16'(code) << PAD;
      frame_c = {2'b00, (lo == hi), 2'b00, lo, 1'b0, d16};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      finish_c   = 1'b0;
      restart_c  = 1'b0;
      case (state)
         S_IDLE:  if (edge_c) state_next = S_EVAL;
         S_EVAL: begin
            if (eval_mask == '0) begin
               finish_c   = 1'b1;
               restart_c  = pend | edge_c;
               state_next = restart_c ? S_EVAL : S_IDLE;
            end else begin
               state_next = S_LOAD;
            end
         end
         S_LOAD:  state_next = S_SETUP;
         S_SETUP: if (phase_end) state_next = S_LOW;
         S_LOW:   if (phase_end) state_next = (bit_cnt == '0) ? S_END : S_HIGH;
         S_HIGH:  if (phase_end) state_next = S_LOW;
         S_END: begin
            if (phase_end) begin
               if (mask_rem != '0) begin
                  state_next = S_LOAD;
               end else begin
                  finish_c   = 1'b1;
                  restart_c  = pend | edge_c;
                  state_next = restart_c ? S_EVAL : S_IDLE;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Datapath and pins; pins follow the state with one register stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trig_prev  <= 1'b0;
         force_q    <= 1'b0;
         pend       <= 1'b0;
         pend_force <= 1'b0;
         valid      <= 1'b0;
         fin_q      <= 1'b0;
         shadow     <= '0;
         cur        <= '0;
         mask       <= '0;
         frame      <= '0;
         bit_cnt    <= '0;
         div_cnt    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         n_sync     <= 1'b1;
         sclk       <= 1'b1;
         data       <= 1'b1;
      end else begin
         trig_prev <= trigger;
         fin_q     <= finish_c;
         div_cnt   <= (state_next != state || phase_end) ? '0 : div_cnt + DW'(1);
         if (restart_c) begin
            pend       <= 1'b0;
            pend_force <= 1'b0;
            force_q    <= pend_force | (edge_c & force_all);
         end else if (edge_c && state != S_IDLE) begin
            pend       <= 1'b1;
            pend_force <= pend_force | force_all;
         end else if (edge_c) begin
            force_q <= force_all;
         end
         if (state == S_EVAL) begin
            cur    <= value;
            shadow <= value;
            valid  <= 1'b1;
            mask   <= eval_mask;
         end
         if (state == S_END && phase_end) mask <= mask_rem;
         if (state == S_LOAD) begin
            frame   <= frame_c;
            bit_cnt <= BW'(23);
         end else if (state == S_LOW && phase_end && bit_cnt != '0) begin
            frame   <= {frame[FW-2:0], 1'b0};
            bit_cnt <= bit_cnt - BW'(1);
         end
         busy   <= (state != S_IDLE) | edge_c;
         done   <= fin_q;
         n_sync <= ~frame_act;
         sclk   <= (state != S_LOW);
         data   <= frame_act ? frame[FW-1] : 1'b1;
      end
   end
endmodule

// File: tb/tb_spi_dac_driver.sv
// Bench for spi_dac_driver: default instance plus a slow 12-bit unsigned always-send variant,
// frames decoded off the pins and scored against an expected-frame queue.
module tb_spi_dac_driver;
   logic        clk = 1'b0;
   logic        rst;
   logic        trig_m, frc_m, trig_v;
   logic [63:0] value_m;
   logic [23:0] value_v;
   logic        busy_m, done_m, ns_m, sc_m, dt_m;
   logic        busy_v, done_v, ns_v, sc_v, dt_v;
   logic [1:0]  ns_w, sc_w, dt_w, bz_w, dn_w;

   int          tests, fails;
   logic [23:0] exp0[$], exp1[$];
   int          fr_cnt[2], nbits[2], ns_len[2], ns_last[2], ph_len[2], ph_bad[2];
   int          busy_len[2], busy_last[2], done_cnt[2], div[2];
   logic [23:0] shreg[2];
   logic        prev_ns[2], prev_sc[2];

   always #5 clk = ~clk;

   assign ns_w = {ns_v, ns_m};
   assign sc_w = {sc_v, sc_m};
   assign dt_w = {dt_v, dt_m};
   assign bz_w = {busy_v, busy_m};
   assign dn_w = {done_v, done_m};

   spi_dac_driver u_main (
      .clk(clk), .rst(rst), .trigger(trig_m), .force_all(frc_m), .value(value_m),
      .busy(busy_m), .done(done_m), .n_sync(ns_m), .sclk(sc_m), .data(dt_m)
   );

   spi_dac_driver #(
      .CHANNELS(2), .DATA_WIDTH(12), .CLK_DIV(3), .SIGNED_IN(0), .UPDATE_CHANGED(0)
   ) u_var (
      .clk(clk), .rst(rst), .trigger(trig_v), .force_all(1'b0), .value(value_v),
      .busy(busy_v), .done(done_v), .n_sync(ns_v), .sclk(sc_v), .data(dt_v)
   );

   // Pin decoder and scoreboard: bits taken on falling SClk, frame closed on nSync rise
   initial begin
      logic        has;
      logic [23:0] want;
      div[0] = 1;
      div[1] = 3;
      for (int i = 0; i < 2; i++) begin
         prev_ns[i] = 1'b1; prev_sc[i] = 1'b1; nbits[i] = 0; ns_len[i] = 0; ph_len[i] = 0;
         ph_bad[i] = 0; fr_cnt[i] = 0; ns_last[i] = 0; busy_len[i] = 0; busy_last[i] = 0;
         done_cnt[i] = 0; shreg[i] = '0;
      end
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (!ns_w[i]) begin
               ns_len[i]++;
               if (prev_ns[i]) ph_len[i] = 1;
               else if (sc_w[i] == prev_sc[i]) ph_len[i]++;
               else begin
                  if (ph_len[i] != div[i]) ph_bad[i]++;
                  ph_len[i] = 1;
               end
               if (prev_sc[i] && !sc_w[i]) begin
                  shreg[i] = {shreg[i][22:0], dt_w[i]};
                  nbits[i]++;
               end
            end else if (!prev_ns[i]) begin
               if (nbits[i] == 24) begin
                  if (ph_len[i] != div[i]) ph_bad[i]++;
                  fr_cnt[i]++;
                  ns_last[i] = ns_len[i];
                  has  = 1'b0;
                  want = '0;
                  if (i == 0 && exp0.size() != 0) begin has = 1'b1; want = exp0.pop_front(); end
                  if (i == 1 && exp1.size() != 0) begin has = 1'b1; want = exp1.pop_front(); end
                  tests++;
                  if (!has) begin
                     fails++;
                     $display("FAIL frame_unexpected dut%0d got %06h, no frame expected", i, shreg[i]);
                  end else if (shreg[i] !== want) begin
                     fails++;
                     $display("FAIL frame dut%0d got %06h expected %06h", i, shreg[i], want);
                  end
               end
               nbits[i]  = 0;
               ns_len[i] = 0;
            end
            if (bz_w[i]) busy_len[i]++;
            else if (busy_len[i] != 0) begin
               busy_last[i] = busy_len[i];
               busy_len[i]  = 0;
            end
            if (dn_w[i]) done_cnt[i]++;
            prev_ns[i] = ns_w[i];
            prev_sc[i] = sc_w[i];
         end
      end
   end

   task automatic pulse(input int i, input logic f);
      @(negedge clk);
      if (i == 0) begin trig_m = 1'b1; frc_m = f; end
      else trig_v = 1'b1;
      @(negedge clk);
      if (i == 0) begin trig_m = 1'b0; frc_m = 1'b0; end
      else trig_v = 1'b0;
   endtask

   task automatic wait_idle(input int i);
      int n = 0;
      while (bz_w[i] && n < 2000) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (bz_w[i]) begin
         fails++;
         $display("FAIL busy_timeout dut%0d still busy after %0d cycles, required idle", i, n);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; trig_m = 1'b0; frc_m = 1'b0; trig_v = 1'b0;
      value_m = '0; value_v = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      tests++;
      if ({ns_m, sc_m, dt_m, busy_m, done_m} !== 5'b11100) begin
         fails++;
         $display("FAIL reset_main pins %05b required 11100", {ns_m, sc_m, dt_m, busy_m, done_m});
      end
      tests++;
      if ({ns_v, sc_v, dt_v, busy_v, done_v} !== 5'b11100) begin
         fails++;
         $display("FAIL reset_var pins %05b required 11100", {ns_v, sc_v, dt_v, busy_v, done_v});
      end
   endtask

   task automatic test_first_trigger();
      int d0 = done_cnt[0];
      int f0 = fr_cnt[0];
      value_m = {16'h7FFF, 16'h8000, 16'h1234, 16'h0000};
      exp0.push_back(24'h008000); exp0.push_back(24'h029234);
      exp0.push_back(24'h040000); exp0.push_back(24'h26FFFF);
      pulse(0, 1'b0);
      wait_idle(0);
      tests++;
      if (busy_last[0] != 202) begin fails++; $display("FAIL first_busy got %0d required 202", busy_last[0]); end
      tests++;
      if (done_cnt[0] - d0 != 1) begin fails++; $display("FAIL first_done got %0d required 1", done_cnt[0] - d0); end
      tests++;
      if (fr_cnt[0] - f0 != 4 || exp0.size() != 0) begin
         fails++; $display("FAIL first_frames got %0d left %0d required 4/0", fr_cnt[0] - f0, exp0.size());
      end
   endtask

   task automatic test_change_filter();
      int d0 = done_cnt[0];
      int f0 = fr_cnt[0];
      pulse(0, 1'b0);
      wait_idle(0);
      tests++;
      if (busy_last[0] != 2) begin fails++; $display("FAIL nochange_busy got %0d required 2", busy_last[0]); end
      tests++;
      if (done_cnt[0] - d0 != 1) begin fails++; $display("FAIL nochange_done got %0d required 1", done_cnt[0] - d0); end
      tests++;
      if (fr_cnt[0] != f0) begin fails++; $display("FAIL nochange_frames got %0d required 0", fr_cnt[0] - f0); end
      value_m[31:16] = 16'h0001;
      exp0.push_back(24'h228001);
      f0 = fr_cnt[0];
      pulse(0, 1'b0);
      wait_idle(0);
      tests++;
      if (busy_last[0] != 52) begin fails++; $display("FAIL onechange_busy got %0d required 52", busy_last[0]); end
      tests++;
      if (fr_cnt[0] - f0 != 1 || exp0.size() != 0) begin
         fails++; $display("FAIL onechange_frames got %0d left %0d required 1/0", fr_cnt[0] - f0, exp0.size());
      end
   endtask

   task automatic test_force();
      int f0 = fr_cnt[0];
      exp0.push_back(24'h008000); exp0.push_back(24'h028001);
      exp0.push_back(24'h040000); exp0.push_back(24'h26FFFF);
      pulse(0, 1'b1);
      wait_idle(0);
      tests++;
      if (busy_last[0] != 202) begin fails++; $display("FAIL force_busy got %0d required 202", busy_last[0]); end
      tests++;
      if (fr_cnt[0] - f0 != 4 || exp0.size() != 0) begin
         fails++; $display("FAIL force_frames got %0d left %0d required 4/0", fr_cnt[0] - f0, exp0.size());
      end
   endtask

   task automatic test_queue();
      int d0 = done_cnt[0];
      int f0 = fr_cnt[0];
      value_m[15:0] = 16'h0005;
      exp0.push_back(24'h208005);
      pulse(0, 1'b0);
      repeat (10) @(negedge clk);
      value_m = {16'h0000, 16'hFFFF, 16'h0001, 16'h0005};
      exp0.push_back(24'h047FFF); exp0.push_back(24'h268000);
      pulse(0, 1'b0);
      repeat (3) @(negedge clk);
      pulse(0, 1'b0);
      wait_idle(0);
      tests++;
      if (busy_last[0] != 153) begin fails++; $display("FAIL queue_busy got %0d required 153", busy_last[0]); end
      tests++;
      if (done_cnt[0] - d0 != 2) begin fails++; $display("FAIL queue_done got %0d required 2", done_cnt[0] - d0); end
      tests++;
      if (fr_cnt[0] - f0 != 3 || exp0.size() != 0) begin
         fails++; $display("FAIL queue_frames got %0d left %0d required 3/0", fr_cnt[0] - f0, exp0.size());
      end
   endtask

   task automatic test_variant();
      value_v = {12'h123, 12'hABC};
      for (int r = 0; r < 2; r++) begin
         int f1 = fr_cnt[1];
         exp1.push_back(24'h00ABC0); exp1.push_back(24'h221230);
         pulse(1, 1'b0);
         wait_idle(1);
         tests++;
         if (busy_last[1] != 298) begin fails++; $display("FAIL var_busy got %0d required 298", busy_last[1]); end
         tests++;
         if (fr_cnt[1] - f1 != 2 || exp1.size() != 0) begin
            fails++; $display("FAIL var_frames got %0d left %0d required 2/0", fr_cnt[1] - f1, exp1.size());
         end
      end
      tests++;
      if (ns_last[1] != 144) begin fails++; $display("FAIL var_nsync_low got %0d required 144", ns_last[1]); end
      tests++;
      if (ph_bad[1] != 0) begin fails++; $display("FAIL var_sclk_phase got %0d bad phases required 0", ph_bad[1]); end
   endtask

   task automatic test_reset_mid_frame();
      int f0 = fr_cnt[0];
      int n  = 0;
      exp0.push_back(24'h008005); exp0.push_back(24'h028001);
      exp0.push_back(24'h047FFF); exp0.push_back(24'h268000);
      pulse(0, 1'b1);
      while (!(fr_cnt[0] == f0 + 1 && nbits[0] == 10) && n < 500) begin
         @(posedge clk);
         n++;
      end
      tests++;
      if (n >= 500) begin fails++; $display("FAIL abort_point_timeout got %0d cycles, required bit 10 of frame 2", n); end
      #2 rst = 1'b1;
      #1;
      tests++;
      if ({ns_m, sc_m, dt_m, busy_m, done_m} !== 5'b11100) begin
         fails++;
         $display("FAIL abort_pins %05b required 11100", {ns_m, sc_m, dt_m, busy_m, done_m});
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      exp0.delete();
      @(negedge clk);
      tests++;
      if (fr_cnt[0] - f0 != 1) begin fails++; $display("FAIL abort_frames got %0d required 1", fr_cnt[0] - f0); end
      f0 = fr_cnt[0];
      exp0.push_back(24'h008005); exp0.push_back(24'h028001);
      exp0.push_back(24'h047FFF); exp0.push_back(24'h268000);
      pulse(0, 1'b0);
      wait_idle(0);
      tests++;
      if (busy_last[0] != 202) begin fails++; $display("FAIL after_abort_busy got %0d required 202", busy_last[0]); end
      tests++;
      if (fr_cnt[0] - f0 != 4 || exp0.size() != 0) begin
         fails++; $display("FAIL after_abort_frames got %0d left %0d required 4/0", fr_cnt[0] - f0, exp0.size());
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_first_trigger();
      test_change_filter();
      test_force();
      test_queue();
      test_variant();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
